arbiter_control: RTL

Control half of the two-cache memory arbiter: decides which cache (cache1 = instruction cache, cache2 = data cache) owns the single physical-memory port and sequences the read/write handshake. Drives `cache_sel` into the arbiter datapath, which steers address and write data, and routes `pmem_resp` back to the granted cache. Read data from physical memory is broadcast to both caches and qualified only by the per-cache response.

---
 rtl/rv32i_types.sv | 33 +++
 rtl/arbiter_control_checker.sv | 36 +++
 rtl/arbiter_control.sv | 100 ++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared control-state types for the RV32I memory subsystem.
// The arbiter state enum lives here so the datapath and benches can decode it.
package rv32i_types;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_C1      = 2'b01,
        ARB_C2      = 2'b10,
        ARB_RELEASE = 2'b11
    } arb_state_t;

    // Grant decision in ARB_IDLE: 1 selects cache2, 0 selects cache1.
    // last_grant = 1 means cache2 was served most recently.
    function automatic logic arb_pick_cache2(
        input logic req1,
        input logic req2,
        input logic last_grant,
        input logic rr_en
    );
        logic pick;
        if (req1 && req2) begin
            if (rr_en) begin
                pick = ~last_grant;
            end else begin
                pick = 1'b1;
            end
        end else begin
            pick = req2;
        end
        return pick;
    endfunction

endpackage

// File: rtl/arbiter_control_checker.sv
// Protocol checks for arbiter_control; instantiated alongside the block in simulation.
module arbiter_control_checker (
    input logic clk,
    input logic rst_n,
    input logic cache1_read,
    input logic cache1_write,
    input logic cache1_resp,
    input logic cache2_read,
    input logic cache2_write,
    input logic cache2_resp,
    input logic pmem_read,
    input logic pmem_write,
    input logic pmem_resp,
    input logic cache_sel
);

    a_single_resp: assert property (@(posedge clk) disable iff (!rst_n)
        !(cache1_resp && cache2_resp));

    a_single_strobe: assert property (@(posedge clk) disable iff (!rst_n)
        !(pmem_read && pmem_write));

    // A granted cache driving read and write together is an illegal request.
    a_c1_rw_illegal: assert property (@(posedge clk) disable iff (!rst_n)
        (pmem_write && !cache_sel) |-> (cache1_write && !cache1_read));

    a_c2_rw_illegal: assert property (@(posedge clk) disable iff (!rst_n)
        (pmem_write && cache_sel) |-> (cache2_write && !cache2_read));

    a_c1_resp_src: assert property (@(posedge clk) disable iff (!rst_n)
        cache1_resp |-> pmem_resp);

    a_c2_resp_src: assert property (@(posedge clk) disable iff (!rst_n)
        cache2_resp |-> pmem_resp);

endmodule

// File: rtl/arbiter_control.sv
// Control FSM of the two-cache memory arbiter: grants the physical-memory port
// to cache1 or cache2, mirrors the granted request onto pmem and routes pmem_resp back.
module arbiter_control
    import rv32i_types::*;
#(
    parameter int RR_ENABLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cache1_read,
    input  logic cache1_write,
    output logic cache1_resp,
    input  logic cache2_read,
    input  logic cache2_write,
    output logic cache2_resp,
    output logic pmem_read,
    output logic pmem_write,
    input  logic pmem_resp,
    output logic cache_sel
);

    localparam logic RR_EN = (RR_ENABLE != 0);

    arb_state_t state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       cache_sel_q, cache_sel_d;
    logic       req1_s, req2_s;

    assign req1_s    = cache1_read | cache1_write;
    assign req2_s    = cache2_read | cache2_write;
    assign cache_sel = cache_sel_q;

    // State, round-robin history and datapath select registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= 1'b1;
            cache_sel_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cache_sel_q  <= cache_sel_d;
        end
    end

    // Next-state decode plus strobes and responses; write wins over read.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cache_sel_d  = cache_sel_q;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        cache1_resp  = 1'b0;
        cache2_resp  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (req1_s || req2_s) begin
                    if (arb_pick_cache2(req1_s, req2_s, last_grant_q, RR_EN)) begin
                        state_d     = ARB_C2;
                        cache_sel_d = 1'b1;
                    end else begin
                        state_d     = ARB_C1;
                        cache_sel_d = 1'b0;
                    end
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_C1: begin
                pmem_write  = cache1_write;
                pmem_read   = cache1_read & ~cache1_write;
                cache1_resp = pmem_resp;
                if (pmem_resp) begin
                    state_d      = ARB_RELEASE;
                    last_grant_d = 1'b0;
                end else begin
                    state_d = ARB_C1;
                end
            end
            ARB_C2: begin
                pmem_write  = cache2_write;
                pmem_read   = cache2_read & ~cache2_write;
                cache2_resp = pmem_resp;
                if (pmem_resp) begin
                    state_d      = ARB_RELEASE;
                    last_grant_d = 1'b1;
                end else begin
                    state_d = ARB_C2;
                end
            end
            ARB_RELEASE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

endmodule
